// File: rtl/mem_access_unit.sv
// Memory-stage controller: one load/store at a time between execute and a 64-word data memory.
// Optional byte access (read-modify-write byte stores) is enabled by defining MEM_ACCESS_BYTE_EN.
module mem_access_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_byte,
  input  logic              req_hi,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef MEM_ACCESS_BYTE_EN
  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, MERGE} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP} state_t;
`endif

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t            stateQ, stateD;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ, rdataQ;
  logic              weQ, faultQ;
  logic              reqReady, memRe, memWe, rspValid;
  logic              accept, isFault;

`ifdef MEM_ACCESS_BYTE_EN
  logic              byteQ, hiQ;
  logic [DATA_W-1:0] mergedWord, loadWord;
`else
  logic              unusedByte;
  assign unusedByte = req_byte ^ req_hi;
`endif

  assign isFault = ({1'b0, req_addr} >= DEPTH_W);
  assign accept  = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (reset) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  always_comb begin
    stateD   = stateQ;
    reqReady = 1'b0;
    memRe    = 1'b0;
    memWe    = 1'b0;
    rspValid = 1'b0;
    case (stateQ)
      IDLE: begin
        reqReady = 1'b1;
        if (req_valid) begin
          if (isFault) stateD = RESP;
`ifdef MEM_ACCESS_BYTE_EN
          else if (req_we && !req_byte) stateD = WRITE;
`else
          else if (req_we) stateD = WRITE;
`endif
          else stateD = READ;
        end
      end
      READ: begin
        memRe = 1'b1;
`ifdef MEM_ACCESS_BYTE_EN
        // A store only passes through READ when it is a byte store needing the old word.
        stateD = weQ ? MERGE : RESP;
`else
        stateD = RESP;
`endif
      end
`ifdef MEM_ACCESS_BYTE_EN
      MERGE: stateD = WRITE;
`endif
      WRITE: begin
        memWe  = 1'b1;
        stateD = RESP;
      end
      RESP: begin
        rspValid = 1'b1;
        if (rsp_ready) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

`ifdef MEM_ACCESS_BYTE_EN
  always_comb begin
    mergedWord = rdataQ;
    if (hiQ) mergedWord[15:8] = wdataQ[7:0];
    else     mergedWord[7:0]  = wdataQ[7:0];
    loadWord = mem_rdata;
    if (byteQ && !weQ) begin
      loadWord = '0;
      loadWord[7:0] = hiQ ? mem_rdata[15:8] : mem_rdata[7:0];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      addrQ  <= '0;
      wdataQ <= '0;
      rdataQ <= '0;
      weQ    <= 1'b0;
      faultQ <= 1'b0;
`ifdef MEM_ACCESS_BYTE_EN
      byteQ  <= 1'b0;
      hiQ    <= 1'b0;
`endif
    end else begin
      case (stateQ)
        IDLE: if (accept) begin
          addrQ  <= req_addr;
          wdataQ <= req_wdata;
          weQ    <= req_we;
          faultQ <= isFault;
          rdataQ <= '0;
`ifdef MEM_ACCESS_BYTE_EN
          byteQ  <= req_byte;
          hiQ    <= req_hi;
`endif
        end
`ifdef MEM_ACCESS_BYTE_EN
        READ: rdataQ <= loadWord;
        MERGE: begin
          wdataQ <= mergedWord;
          rdataQ <= '0;
        end
`else
        READ: rdataQ <= mem_rdata;
`endif
        default: ;
      endcase
    end
  end

  assign req_ready = reqReady & ~reset;
  assign mem_re    = memRe & ~reset;
  assign mem_we    = memWe & ~reset;
  assign rsp_valid = rspValid;
  assign rsp_rdata = rdataQ;
  assign rsp_fault = faultQ;
  assign mem_addr  = (stateQ == IDLE) ? '0 : addrQ;
  assign mem_wdata = (stateQ == IDLE) ? '0 : wdataQ;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 64-word falling-edge memory plus a response scoreboard.
module tb_mem_access_unit;
  logic        clk, reset;
  logic        req_valid, req_ready, req_we, req_byte, req_hi;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_fault;
  logic [15:0] rsp_rdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] tbMem [64];
  int passCnt = 0, totalCnt = 0;
  int weCnt = 0, reCnt = 0, bothCnt = 0;

  typedef struct {
    logic [15:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;
  exp_t sb[$];

  mem_access_unit #(.DATA_W(16), .ADDR_W(8), .DEPTH(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byte(req_byte), .req_hi(req_hi),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: combinational read, write committed on the falling edge.
  assign mem_rdata = (mem_addr < 8'd64) ? tbMem[mem_addr[5:0]] : 16'h0000;
  always @(negedge clk) begin
    if (mem_we && mem_addr < 8'd64) tbMem[mem_addr[5:0]] <= mem_wdata;
    if (mem_we) weCnt++;
    if (mem_re) reCnt++;
    if (mem_we && mem_re) bothCnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReq(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                       input logic byt, input logic hi, input int lat,
                       input logic [15:0] expData, input int hold);
    exp_t e;
    int cyc, weBefore, reBefore;
    e.fault = (addr >= 8'd64);
    e.rdata = e.fault ? 16'h0000 : expData;
    e.lat   = lat;
    sb.push_back(e);
    check("req_ready_idle", req_ready, 1);
    weBefore = weCnt;
    reBefore = reCnt;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_byte = byt; req_hi = hi;
    tick();
    req_valid = 1'b0;
    cyc = 1;
    if (addr < 8'd64 && !(byt && we)) begin
      if (we) begin
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, addr);
        check("wr_mem_wdata", mem_wdata, wdata);
      end else begin
        check("rd_mem_re", mem_re, 1);
        check("rd_mem_addr", mem_addr, addr);
      end
    end
    while (!rsp_valid && cyc < 12) begin
      tick();
      cyc++;
    end
    e = sb.pop_front();
    check("rsp_latency", cyc, e.lat);
    check("rsp_rdata", rsp_rdata, e.rdata);
    check("rsp_fault", rsp_fault, e.fault);
    if (e.fault) begin
      check("fault_no_we", weCnt, weBefore);
      check("fault_no_re", reCnt, reBefore);
    end else if (we) begin
      check("store_one_we", weCnt, weBefore + 1);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, e.rdata);
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    check("resp_req_ready", req_ready, 0);
    tick();
    rsp_ready = 1'b0;
    check("after_rsp_valid", rsp_valid, 0);
    check("after_req_ready", req_ready, 1);
  endtask

  initial begin
    int weSnap;
    for (int i = 0; i < 64; i++) tbMem[i] = 16'h0000;
    tbMem[2] = 16'h1234;
    tbMem[3] = 16'h1234;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_byte = 1'b0; req_hi = 1'b0; rsp_ready = 1'b0;

    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_fault", rsp_fault, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 1);
    tick();
    tick();
    check("post_rst_no_we", weCnt, 0);

    doReq(1'b1, 8'd1, 16'hBEEF, 1'b0, 1'b0, 2, 16'h0000, 0);
    check("mem1_written", tbMem[1], 16'hBEEF);
    doReq(1'b0, 8'd1, 16'h0000, 1'b0, 1'b0, 2, 16'hBEEF, 0);
    doReq(1'b0, 8'h40, 16'h0000, 1'b0, 1'b0, 1, 16'h0000, 0);
    doReq(1'b1, 8'hFF, 16'hAAAA, 1'b0, 1'b0, 1, 16'h0000, 0);
    doReq(1'b0, 8'd2, 16'h0000, 1'b0, 1'b0, 2, 16'h1234, 3);
    doReq(1'b1, 8'd63, 16'h0F0F, 1'b0, 1'b0, 2, 16'h0000, 1);
    doReq(1'b0, 8'd63, 16'h0000, 1'b0, 1'b0, 2, 16'h0F0F, 0);

    // Reset raised during the WRITE cycle must suppress the commit.
    weSnap = weCnt;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd5; req_wdata = 16'h5A5A;
    tick();
    req_valid = 1'b0;
    check("midwr_we_before", mem_we, 1);
    reset = 1'b1;
    #1;
    check("midwr_we_gated", mem_we, 0);
    tick();
    reset = 1'b0;
    #1;
    check("midwr_rsp_valid", rsp_valid, 0);
    check("midwr_req_ready", req_ready, 1);
    check("midwr_no_commit", tbMem[5], 16'h0000);
    check("midwr_we_count", weCnt, weSnap);
    doReq(1'b0, 8'd5, 16'h0000, 1'b0, 1'b0, 2, 16'h0000, 0);

`ifdef MEM_ACCESS_BYTE_EN
    doReq(1'b1, 8'd3, 16'h00AB, 1'b1, 1'b1, 4, 16'h0000, 0);
    check("byte_store_word", tbMem[3], 16'hAB34);
    doReq(1'b0, 8'd3, 16'h0000, 1'b1, 1'b0, 2, 16'h0034, 0);
    doReq(1'b0, 8'd3, 16'h0000, 1'b1, 1'b1, 2, 16'h00AB, 0);
    doReq(1'b1, 8'h50, 16'h00CD, 1'b1, 1'b0, 1, 16'h0000, 0);
`else
    doReq(1'b1, 8'd6, 16'h7788, 1'b1, 1'b1, 2, 16'h0000, 0);
    check("byte_ignored_word", tbMem[6], 16'h7788);
    doReq(1'b0, 8'd6, 16'h0000, 1'b1, 1'b0, 2, 16'h7788, 0);
`endif

    check("never_both_enables", bothCnt, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
